// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer
// Sequential initiator for a combinational signed 8-bit calculator. Accepts a
// command on a valid/ready channel, launches operands from registers, waits a
// fixed settle time, captures the answer and returns it on a valid/ready
// response channel. Supports result chaining, divide-by-zero sanitising and a
// saturating overflow event counter.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/ready            command handshake
//   cmd_op/a/b/chain           command payload (chain: operand a = last result)
//   rsp_valid/ready            response handshake
//   rsp_result/overflow/divzero response payload
//   calc_a/b/op                operands driven to the calculator
//   calc_result/overflow       answer from the calculator
//   ovf_clr, ovf_count         overflow counter clear and value
//   busy                       sequencer is not idle
module calc_op_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [7:0]       cmd_a,
   input  logic [7:0]       cmd_b,
   input  logic             cmd_chain,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [7:0]       rsp_result,
   output logic             rsp_overflow,
   output logic             rsp_divzero,
   output logic [7:0]       calc_a,
   output logic [7:0]       calc_b,
   output logic [1:0]       calc_op,
   input  logic [7:0]       calc_result,
   input  logic             calc_overflow,
   input  logic             ovf_clr,
   output logic [CNT_W-1:0] ovf_count,
   output logic             busy
);

   typedef enum logic [1:0] {StIdle, StSettle, StResp} state_t;

   state_t           state_q, state_d;
   logic [3:0]       wait_q, wait_d;
   logic [7:0]       calc_a_q, calc_a_d;
   logic [7:0]       calc_b_q, calc_b_d;
   logic [1:0]       calc_op_q, calc_op_d;
   logic [7:0]       result_q, result_d;
   logic             overflow_q, overflow_d;
   logic             divzero_q, divzero_d;
   logic [7:0]       last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             div_by_zero;
   logic [7:0]       cap_result;
   logic             cap_overflow;

   // Divide by zero never looks at calc_result, so an undefined calculator
   // output cannot leak onto the response.
   assign div_by_zero  = (calc_op_q == 2'b11) && (calc_b_q == 8'd0);
   assign cap_result   = div_by_zero ? 8'd0 : calc_result;
   assign cap_overflow = div_by_zero ? 1'b1 : calc_overflow;

   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      calc_a_d   = calc_a_q;
      calc_b_d   = calc_b_q;
      calc_op_d  = calc_op_q;
      result_d   = result_q;
      overflow_d = overflow_q;
      divzero_d  = divzero_q;
      last_d     = last_q;
      cnt_d      = cnt_q;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               calc_a_d  = cmd_chain ? last_q : cmd_a;
               calc_b_d  = cmd_b;
               calc_op_d = cmd_op;
               wait_d    = 4'(SETTLE_CYCLES);
               state_d   = StSettle;
            end
         end
         StSettle: begin
            wait_d = wait_q - 4'd1;
            if (wait_q == 4'd1) begin
               result_d   = cap_result;
               overflow_d = cap_overflow;
               divzero_d  = div_by_zero;
               last_d     = cap_result;
               if (cap_overflow && (cnt_q != {CNT_W{1'b1}})) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               state_d = StResp;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Clear takes priority over a coincident increment.
      if (ovf_clr) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         wait_q     <= 4'd0;
         calc_a_q   <= 8'd0;
         calc_b_q   <= 8'd0;
         calc_op_q  <= 2'd0;
         result_q   <= 8'd0;
         overflow_q <= 1'b0;
         divzero_q  <= 1'b0;
         last_q     <= 8'd0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         calc_a_q   <= calc_a_d;
         calc_b_q   <= calc_b_d;
         calc_op_q  <= calc_op_d;
         result_q   <= result_d;
         overflow_q <= overflow_d;
         divzero_q  <= divzero_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
      end
   end

   assign cmd_ready    = (state_q == StIdle);
   assign busy         = !cmd_ready;
   assign rsp_valid    = (state_q == StResp);
   assign rsp_result   = result_q;
   assign rsp_overflow = overflow_q;
   assign rsp_divzero  = divzero_q;
   assign calc_a       = calc_a_q;
   assign calc_b       = calc_b_q;
   assign calc_op      = calc_op_q;
   assign ovf_count    = cnt_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench: instance 0 uses SETTLE_CYCLES=1/CNT_W=8, instance 1 uses
// SETTLE_CYCLES=3/CNT_W=2. A behavioural calculator answers each instance.
module tb_calc_op_sequencer;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid [2];
   logic       cmd_ready [2];
   logic [1:0] cmd_op    [2];
   logic [7:0] cmd_a     [2];
   logic [7:0] cmd_b     [2];
   logic       cmd_chain [2];
   logic       rsp_valid [2];
   logic       rsp_ready [2];
   logic [7:0] rsp_result[2];
   logic       rsp_ovf   [2];
   logic       rsp_dz    [2];
   logic [7:0] ca        [2];
   logic [7:0] cb        [2];
   logic [1:0] co        [2];
   logic       ovf_clr   [2];
   logic       busy      [2];
   logic [7:0] calc_res0, calc_res1;
   logic       calc_ovf0, calc_ovf1;
   logic [7:0] ovf_cnt0;
   logic [1:0] ovf_cnt1;

   int n_cmp = 0;
   int n_err = 0;

   calc_op_sequencer #(.SETTLE_CYCLES(1), .CNT_W(8)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
      .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_chain(cmd_chain[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]),
      .rsp_overflow(rsp_ovf[0]), .rsp_divzero(rsp_dz[0]),
      .calc_a(ca[0]), .calc_b(cb[0]), .calc_op(co[0]),
      .calc_result(calc_res0), .calc_overflow(calc_ovf0),
      .ovf_clr(ovf_clr[0]), .ovf_count(ovf_cnt0), .busy(busy[0])
   );

   calc_op_sequencer #(.SETTLE_CYCLES(3), .CNT_W(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
      .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_chain(cmd_chain[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]),
      .rsp_overflow(rsp_ovf[1]), .rsp_divzero(rsp_dz[1]),
      .calc_a(ca[1]), .calc_b(cb[1]), .calc_op(co[1]),
      .calc_result(calc_res1), .calc_overflow(calc_ovf1),
      .ovf_clr(ovf_clr[1]), .ovf_count(ovf_cnt1), .busy(busy[1])
   );

   // Signed 8-bit calculator; divide by zero drives X.
   function automatic void calc_model(input logic [7:0] a, input logic [7:0] b,
                                      input logic [1:0] op,
                                      output logic [7:0] r, output logic ovf);
      int sa, sb, w;
      sa = int'($signed(a));
      sb = int'($signed(b));
      case (op)
         2'b00:   w = sa + sb;
         2'b01:   w = sa - sb;
         2'b10:   w = sa * sb;
         default: begin
            if (sb == 0) begin
               r   = 'x;
               ovf = 1'bx;
               return;
            end
            w = sa / sb;
         end
      endcase
      r   = w[7:0];
      ovf = (w > 127) || (w < -128);
   endfunction

   always_comb calc_model(ca[0], cb[0], co[0], calc_res0, calc_ovf0);
   always_comb calc_model(ca[1], cb[1], co[1], calc_res1, calc_ovf1);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] cnt_of(input int i);
      return (i == 0) ? ovf_cnt0 : {6'd0, ovf_cnt1};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a command and complete the accept handshake.
   task automatic send(input int i, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic ch, input logic [7:0] exp_a);
      check("cmd_ready_before", 32'(cmd_ready[i]), 32'd1);
      cmd_op[i] = op; cmd_a[i] = a; cmd_b[i] = b; cmd_chain[i] = ch;
      cmd_valid[i] = 1'b1;
      tick();
      cmd_valid[i] = 1'b0;
      check("calc_a_launch", 32'(ca[i]), 32'(exp_a));
      check("busy_after_accept", 32'(busy[i]), 32'd1);
   endtask

   task automatic wait_rsp(input int i, input int lat);
      int n = 0;
      while (!rsp_valid[i] && n < 20) begin
         tick();
         n++;
      end
      check("rsp_latency", 32'(n), 32'(lat));
   endtask

   task automatic check_rsp(input int i, input logic [7:0] r, input logic o, input logic d);
      check("rsp_result", 32'(rsp_result[i]), 32'(r));
      check("rsp_overflow", 32'(rsp_ovf[i]), 32'(o));
      check("rsp_divzero", 32'(rsp_dz[i]), 32'(d));
   endtask

   task automatic take_rsp(input int i);
      rsp_ready[i] = 1'b1;
      tick();
      rsp_ready[i] = 1'b0;
      check("rsp_valid_drop", 32'(rsp_valid[i]), 32'd0);
      check("cmd_ready_back", 32'(cmd_ready[i]), 32'd1);
   endtask

   task automatic run(input int i, input logic [1:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic ch, input logic [7:0] exp_a,
                      input logic [7:0] r, input logic o, input logic d, input int lat,
                      input logic [7:0] cnt);
      send(i, op, a, b, ch, exp_a);
      wait_rsp(i, lat);
      check_rsp(i, r, o, d);
      check("ovf_count", 32'(cnt_of(i)), 32'(cnt));
      take_rsp(i);
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cmd_valid[i] = 1'b0; cmd_op[i] = 2'd0; cmd_a[i] = 8'd0; cmd_b[i] = 8'd0;
         cmd_chain[i] = 1'b0; rsp_ready[i] = 1'b0; ovf_clr[i] = 1'b0;
      end
      #2;
      check("rst_cmd_ready", 32'(cmd_ready[0]), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      check("rst_calc_a", 32'(ca[0]), 32'd0);
      check("rst_ovf_count", 32'(ovf_cnt0), 32'd0);
      #10;
      rst_n = 1'b1;
      tick();

      // Instance 0: SETTLE_CYCLES=1
      run(0, 2'b00, 8'd100, 8'd27, 1'b0, 8'd100, 8'd127, 1'b0, 1'b0, 1, 8'd0);
      run(0, 2'b00, 8'd100, 8'd28, 1'b0, 8'd100, 8'h80, 1'b1, 1'b0, 1, 8'd1);
      run(0, 2'b10, 8'd16, 8'd16, 1'b0, 8'd16, 8'h00, 1'b1, 1'b0, 1, 8'd2);
      // Divide by zero with X from the calculator.
      send(0, 2'b11, 8'd5, 8'd0, 1'b0, 8'd5);
      wait_rsp(0, 1);
      check_rsp(0, 8'd0, 1'b1, 1'b1);
      check("dz_no_x", 32'($isunknown({rsp_result[0], rsp_ovf[0], rsp_dz[0], ovf_cnt0})),
            32'd0);
      check("dz_count", 32'(ovf_cnt0), 32'd3);
      take_rsp(0);
      // Chaining: 10*5=50, then 50-60=-10, 7/-2=-3, -3/-2=1.
      run(0, 2'b10, 8'd10, 8'd5, 1'b0, 8'd10, 8'd50, 1'b0, 1'b0, 1, 8'd3);
      run(0, 2'b01, 8'd99, 8'd60, 1'b1, 8'd50, 8'hF6, 1'b0, 1'b0, 1, 8'd3);
      run(0, 2'b11, 8'd7, 8'hFE, 1'b0, 8'd7, 8'hFD, 1'b0, 1'b0, 1, 8'd3);
      run(0, 2'b11, 8'd0, 8'hFE, 1'b1, 8'hFD, 8'd1, 1'b0, 1'b0, 1, 8'd3);

      // Instance 1: SETTLE_CYCLES=3, backpressure.
      send(1, 2'b00, 8'd1, 8'd2, 1'b0, 8'd1);
      wait_rsp(1, 3);
      check_rsp(1, 8'd3, 1'b0, 1'b0);
      cmd_valid[1] = 1'b1; cmd_a[1] = 8'd77; cmd_b[1] = 8'd9;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("bp_rsp_valid", 32'(rsp_valid[1]), 32'd1);
         check("bp_rsp_result", 32'(rsp_result[1]), 32'd3);
         check("bp_cmd_ready", 32'(cmd_ready[1]), 32'd0);
         check("bp_calc_a", 32'(ca[1]), 32'd1);
      end
      cmd_valid[1] = 1'b0;
      take_rsp(1);

      // Saturation with CNT_W=2.
      run(1, 2'b00, 8'd127, 8'd1, 1'b0, 8'd127, 8'h80, 1'b1, 1'b0, 3, 8'd1);
      run(1, 2'b00, 8'd127, 8'd1, 1'b0, 8'd127, 8'h80, 1'b1, 1'b0, 3, 8'd2);
      run(1, 2'b00, 8'd127, 8'd1, 1'b0, 8'd127, 8'h80, 1'b1, 1'b0, 3, 8'd3);
      run(1, 2'b00, 8'd127, 8'd1, 1'b0, 8'd127, 8'h80, 1'b1, 1'b0, 3, 8'd3);
      // Clear coincident with an overflow capture.
      send(1, 2'b01, 8'h80, 8'd1, 1'b0, 8'h80);
      tick();
      tick();
      check("clr_pre_count", 32'(ovf_cnt1), 32'd3);
      check("clr_pre_valid", 32'(rsp_valid[1]), 32'd0);
      ovf_clr[1] = 1'b1;
      tick();
      ovf_clr[1] = 1'b0;
      check("clr_capture_valid", 32'(rsp_valid[1]), 32'd1);
      check_rsp(1, 8'h7F, 1'b1, 1'b0);
      check("clr_wins", 32'(ovf_cnt1), 32'd0);
      take_rsp(1);

      // Reset in SETTLE on instance 1 (3 settle cycles leaves room).
      send(1, 2'b00, 8'd40, 8'd2, 1'b0, 8'd40);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy[1]), 32'd0);
      check("mid_rst_calc_a", 32'(ca[1]), 32'd0);
      check("mid_rst_calc_b", 32'(cb[1]), 32'd0);
      check("mid_rst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
      check("mid_rst_result", 32'(rsp_result[1]), 32'd0);
      check("mid_rst_cnt0", 32'(ovf_cnt0), 32'd0);
      #7;
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("mid_rst_no_rsp", 32'(rsp_valid[1]), 32'd0);
      end
      run(1, 2'b00, 8'd99, 8'd5, 1'b1, 8'd0, 8'd5, 1'b0, 1'b0, 3, 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
